col_proj_ctrl: RTL and testbench

Sequencer for the 1-bit column-projection RAM used by the digital-recognition pipeline. Per frame it clears the RAM, then marks every column that contains a foreground pixel during the frame. At frame end it scans the RAM and reports each contiguous run of marked columns as a digit segment (left/right column) for the downstream recognition stage. The controller is the RAM's only writer and reader.

---
 rtl/col_proj_ctrl_if.sv | 42 ++++
 rtl/col_proj_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_col_proj_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/col_proj_ctrl_if.sv
// Bundle of pixel-stream, projection-RAM and segment-report signals for col_proj_ctrl.
// The controller takes the slave view; the surrounding pipeline and RAM take the master view.
interface col_proj_ctrl_if #(
    parameter int DEPBIT  = 10,
    parameter int SEG_BIT = 4
);
    // Valid semantics: pix_valid qualifies pix_bin/pix_x in the cycle it is high and
    // seg_valid qualifies seg_left/seg_right in the cycle it is high. Neither has a
    // ready: there is no backpressure, so every qualified beat is consumed or
    // presented exactly once. frame_start, frame_end and done are single-cycle pulses.
    logic              frame_start;
    logic              frame_end;
    logic              pix_valid;
    logic              pix_bin;
    logic [DEPBIT-1:0] pix_x;

    logic              ram_we;
    logic [DEPBIT-1:0] ram_waddr;
    logic              ram_dq_i;
    logic [DEPBIT-1:0] ram_raddr;
    logic              ram_dq_o;

    logic              busy;
    logic              seg_valid;
    logic [DEPBIT-1:0] seg_left;
    logic [DEPBIT-1:0] seg_right;
    logic [SEG_BIT-1:0] seg_cnt;
    logic              seg_ovf;
    logic              done;

    modport master (
        output frame_start, frame_end, pix_valid, pix_bin, pix_x, ram_dq_o,
        input  ram_we, ram_waddr, ram_dq_i, ram_raddr,
        input  busy, seg_valid, seg_left, seg_right, seg_cnt, seg_ovf, done
    );

    modport slave (
        input  frame_start, frame_end, pix_valid, pix_bin, pix_x, ram_dq_o,
        output ram_we, ram_waddr, ram_dq_i, ram_raddr,
        output busy, seg_valid, seg_left, seg_right, seg_cnt, seg_ovf, done
    );
endinterface

// File: rtl/col_proj_ctrl.sv
// Column-projection sequencer: clears the 1-bit RAM, marks foreground columns, then scans runs into segments.
// Optional macro PROJ_MIN_WIDTH_EN drops segments narrower than MIN_W columns.
module col_proj_ctrl #(
    parameter int H_PIXEL = 640,
    parameter int DEPBIT  = 10,
    parameter int MAX_SEG = 8,
    parameter int SEG_BIT = 4,
    parameter int MIN_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    col_proj_ctrl_if.slave      bus,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_SCAN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [DEPBIT-1:0]  LAST_COL  = DEPBIT'(H_PIXEL - 1);
    localparam logic [SEG_BIT-1:0] SEG_LIMIT = SEG_BIT'(MAX_SEG);
`ifdef PROJ_MIN_WIDTH_EN
    localparam int WIDTH_FLOOR = MIN_W;
`else
    // Every run is at least one column wide, so this floor never discards a segment.
    localparam int WIDTH_FLOOR = (MIN_W < 1) ? MIN_W : 1;
`endif

    state_t state_q, state_d;

    logic [DEPBIT-1:0]  clr_cnt_q, clr_cnt_d;
    logic               prev_q, prev_d;
    logic [DEPBIT-1:0]  left_q, left_d;
    logic [SEG_BIT-1:0] count_q, count_d;
    logic               ovf_flag_q, ovf_flag_d;

    logic               ram_we_q, ram_we_d;
    logic [DEPBIT-1:0]  ram_waddr_q, ram_waddr_d;
    logic               ram_dq_i_q, ram_dq_i_d;
    logic [DEPBIT-1:0]  ram_raddr_q, ram_raddr_d;
    logic               busy_q, busy_d;
    logic               seg_valid_q, seg_valid_d;
    logic [DEPBIT-1:0]  seg_left_q, seg_left_d;
    logic [DEPBIT-1:0]  seg_right_q, seg_right_d;
    logic [SEG_BIT-1:0] seg_cnt_q, seg_cnt_d;
    logic               seg_ovf_q, seg_ovf_d;
    logic               done_q, done_d;

    logic               pix_hit;
    logic               scan_bit;
    logic               last_col;
    logic               seg_close;
    logic               seg_keep;
    logic [DEPBIT-1:0]  close_left;
    logic [DEPBIT-1:0]  close_right;
    logic [DEPBIT-1:0]  seg_width;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            clr_cnt_q   <= '0;
            prev_q      <= 1'b0;
            left_q      <= '0;
            count_q     <= '0;
            ovf_flag_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_dq_i_q  <= 1'b0;
            ram_raddr_q <= '0;
            busy_q      <= 1'b0;
            seg_valid_q <= 1'b0;
            seg_left_q  <= '0;
            seg_right_q <= '0;
            seg_cnt_q   <= '0;
            seg_ovf_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            prev_q      <= prev_d;
            left_q      <= left_d;
            count_q     <= count_d;
            ovf_flag_q  <= ovf_flag_d;
            ram_we_q    <= ram_we_d;
            ram_waddr_q <= ram_waddr_d;
            ram_dq_i_q  <= ram_dq_i_d;
            ram_raddr_q <= ram_raddr_d;
            busy_q      <= busy_d;
            seg_valid_q <= seg_valid_d;
            seg_left_q  <= seg_left_d;
            seg_right_q <= seg_right_d;
            seg_cnt_q   <= seg_cnt_d;
            seg_ovf_q   <= seg_ovf_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; frame_start restarts the frame from any state.
    always_comb begin
        state_d = state_q;
        if (bus.frame_start) begin
            state_d = S_CLEAR;
        end else begin
            case (state_q)
                S_CLEAR: if (clr_cnt_q == LAST_COL) state_d = S_ACCUM;
                S_ACCUM: if (bus.frame_end) state_d = S_SCAN;
                S_SCAN:  if (last_col) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Run detection on the bit read at column ram_raddr_q.
    always_comb begin
        pix_hit  = bus.pix_valid && bus.pix_bin && (bus.pix_x <= LAST_COL);
        scan_bit = bus.ram_dq_o;
        last_col = (ram_raddr_q == LAST_COL);
        // A run starting on the last column has not latched left yet.
        close_left = prev_q ? left_q : ram_raddr_q;
        if (scan_bit && last_col) begin
            seg_close   = 1'b1;
            close_right = LAST_COL;
        end else begin
            seg_close   = !scan_bit && prev_q;
            close_right = ram_raddr_q - DEPBIT'(1);
        end
        seg_width = close_right - close_left + DEPBIT'(1);
        seg_keep  = (seg_width >= DEPBIT'(WIDTH_FLOOR));
    end

    // Output and datapath logic.
    always_comb begin
        clr_cnt_d   = clr_cnt_q;
        prev_d      = prev_q;
        left_d      = left_q;
        count_d     = count_q;
        ovf_flag_d  = ovf_flag_q;
        ram_we_d    = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_dq_i_d  = 1'b0;
        ram_raddr_d = ram_raddr_q;
        seg_valid_d = 1'b0;
        seg_left_d  = seg_left_q;
        seg_right_d = seg_right_q;
        seg_cnt_d   = seg_cnt_q;
        seg_ovf_d   = seg_ovf_q;
        done_d      = 1'b0;
        busy_d      = (state_d == S_CLEAR) || (state_d == S_ACCUM) || (state_d == S_SCAN);

        if (bus.frame_start) begin
            clr_cnt_d   = '0;
            ram_we_d    = 1'b1;
            ram_waddr_d = DEPBIT'(1);
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (clr_cnt_q != LAST_COL) begin
                        clr_cnt_d   = clr_cnt_q + DEPBIT'(1);
                        ram_we_d    = 1'b1;
                        ram_waddr_d = clr_cnt_q + DEPBIT'(2);
                    end
                end
                S_ACCUM: begin
                    if (pix_hit) begin
                        ram_we_d    = 1'b1;
                        ram_waddr_d = bus.pix_x + DEPBIT'(1);
                        ram_dq_i_d  = 1'b1;
                    end
                    if (bus.frame_end) begin
                        ram_raddr_d = '0;
                        prev_d      = 1'b0;
                        count_d     = '0;
                        ovf_flag_d  = 1'b0;
                    end
                end
                S_SCAN: begin
                    prev_d = scan_bit;
                    if (scan_bit && !prev_q) left_d = ram_raddr_q;
                    if (seg_close && seg_keep) begin
                        if (count_q < SEG_LIMIT) begin
                            seg_valid_d = 1'b1;
                            seg_left_d  = close_left;
                            seg_right_d = close_right;
                            count_d     = count_q + SEG_BIT'(1);
                        end else begin
                            ovf_flag_d = 1'b1;
                        end
                    end
                    // Totals include a segment closing on the final column.
                    if (last_col) begin
                        done_d    = 1'b1;
                        seg_cnt_d = count_d;
                        seg_ovf_d = ovf_flag_d;
                    end else begin
                        ram_raddr_d = ram_raddr_q + DEPBIT'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_waddr = ram_waddr_q;
    assign bus.ram_dq_i  = ram_dq_i_q;
    assign bus.ram_raddr = ram_raddr_q;
    assign bus.busy      = busy_q;
    assign bus.seg_valid = seg_valid_q;
    assign bus.seg_left  = seg_left_q;
    assign bus.seg_right = seg_right_q;
    assign bus.seg_cnt   = seg_cnt_q;
    assign bus.seg_ovf   = seg_ovf_q;
    assign bus.done      = done_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_col_proj_ctrl.sv
// Self-checking bench for col_proj_ctrl with a behavioural 1-bit projection RAM.
// Expected segments come from a run-finding model of the columns the bench marks.
module tb_col_proj_ctrl;

  localparam int H_PIXEL = 32;
  localparam int DEPBIT  = 6;
  localparam int MAX_SEG = 8;
  localparam int SEG_BIT = 4;
`ifdef PROJ_MIN_WIDTH_EN
  localparam int MIN_W       = 2;
  localparam int MIN_W_MODEL = 2;
`else
  localparam int MIN_W       = 4;
  localparam int MIN_W_MODEL = 1;
`endif
  localparam int W = 2 * DEPBIT;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ACCUM = 3'd2;
  localparam logic [2:0] ST_SCAN  = 3'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] dbg_state;
  col_proj_ctrl_if #(.DEPBIT(DEPBIT), .SEG_BIT(SEG_BIT)) bus ();

  col_proj_ctrl #(
    .H_PIXEL(H_PIXEL), .DEPBIT(DEPBIT), .MAX_SEG(MAX_SEG), .SEG_BIT(SEG_BIT), .MIN_W(MIN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  // RAM model: stores at waddr-1, filled with ones during reset so clearing is observable
  logic mem [0:H_PIXEL-1];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < H_PIXEL; i++) mem[i] <= 1'b1;
    end else if (bus.ram_we && bus.ram_waddr != '0 && int'(bus.ram_waddr) <= H_PIXEL) begin
      mem[int'(bus.ram_waddr) - 1] <= bus.ram_dq_i;
    end
  end
  assign bus.ram_dq_o = (int'(bus.ram_raddr) < H_PIXEL) ? mem[int'(bus.ram_raddr)] : 1'b0;

  // cycle counter and output monitor
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]      obs_q[$];
  int unsigned       obs_cyc_q[$];
  int unsigned       wr_cyc_q[$];
  logic [DEPBIT-1:0] wr_addr_q[$];
  logic              wr_dat_q[$];
  int unsigned       done_cnt = 0;
  int unsigned       done_cyc = 0;

  always @(negedge clk) begin
    if (bus.seg_valid) begin
      obs_q.push_back({bus.seg_left, bus.seg_right});
      obs_cyc_q.push_back(cyc);
    end
    if (bus.ram_we) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(bus.ram_waddr);
      wr_dat_q.push_back(bus.ram_dq_i);
    end
    if (bus.done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           last_cnt = 0;
  bit           last_ovf = 1'b0;
  int unsigned  last_emit_cyc = 0;

  function automatic void build_exp(input logic [H_PIXEL-1:0] mask, output int cnt, output bit ovf);
    int x;
    int l;
    cnt = 0;
    ovf = 1'b0;
    x = 0;
    while (x < H_PIXEL) begin
      if (mask[x]) begin
        l = x;
        while (x < H_PIXEL && mask[x]) x++;
        if (x - l >= MIN_W_MODEL) begin
          if (cnt < MAX_SEG) begin
            exp_q.push_back({DEPBIT'(l), DEPBIT'(x - 1)});
            cnt++;
          end else begin
            ovf = 1'b1;
          end
        end
      end else begin
        x++;
      end
    end
  endfunction

  // driver tasks (all start and end at posedge + 1)
  task automatic pulse_start(output int unsigned c0);
    bus.frame_start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
  endtask

  task automatic pulse_end(output int unsigned c0);
    bus.frame_end = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    bus.frame_end = 1'b0;
  endtask

  task automatic feed_pixels(input logic [H_PIXEL-1:0] mask);
    for (int x = 0; x < H_PIXEL; x++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.pix_valid = 1'b0;
        bus.pix_bin   = 1'b1;
        bus.pix_x     = DEPBIT'($urandom_range(0, H_PIXEL - 1));
        @(posedge clk); #1;
      end
      bus.pix_valid = 1'b1;
      bus.pix_bin   = mask[x];
      bus.pix_x     = DEPBIT'(x);
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
    bus.pix_bin   = 1'b0;
    bus.pix_x     = '0;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input logic [H_PIXEL-1:0] mask, output int unsigned fe);
    int unsigned c0;
    pulse_start(c0);
    repeat (H_PIXEL) @(posedge clk);
    #1;
    feed_pixels(mask);
    pulse_end(fe);
  endtask

  task automatic wait_done(input int unsigned base, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 4 * H_PIXEL && !seen; i++) begin
      @(posedge clk); #1;
      if (done_cnt != base) seen = 1'b1;
    end
  endtask

  // tests
  task automatic test_reset();
    logic [3*DEPBIT+SEG_BIT+6:0] outs;
    outs = {bus.ram_we, bus.ram_waddr, bus.ram_dq_i, bus.ram_raddr, bus.busy, bus.seg_valid,
            bus.seg_left, bus.seg_right, bus.seg_cnt, bus.seg_ovf, bus.done};
    n_vec++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_clear();
    int unsigned c0, fe, base;
    bit seen;
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_dat_q.delete();
    obs_q.delete(); obs_cyc_q.delete();
    base = done_cnt;
    pulse_start(c0);
    n_vec++;
    if (dbg_state !== ST_CLEAR || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL clear_entry: state %0d busy %b expected %0d 1", dbg_state, bus.busy, ST_CLEAR);
    end
    repeat (H_PIXEL) @(posedge clk);
    #1;
    n_vec++;
    if (dbg_state !== ST_ACCUM || cyc != c0 + H_PIXEL + 1) begin
      n_err++;
      $display("FAIL clear_to_accum: state %0d at cycle +%0d expected %0d at +%0d",
               dbg_state, cyc - c0, ST_ACCUM, H_PIXEL + 1);
    end
    n_vec++;
    if (wr_cyc_q.size() != H_PIXEL) begin
      n_err++;
      $display("FAIL clear_write_count: got %0d expected %0d", wr_cyc_q.size(), H_PIXEL);
    end
    for (int i = 0; i < H_PIXEL && wr_cyc_q.size() > 0; i++) begin
      int unsigned wc;
      logic [DEPBIT-1:0] wa;
      logic wd;
      wc = wr_cyc_q.pop_front();
      wa = wr_addr_q.pop_front();
      wd = wr_dat_q.pop_front();
      n_vec++;
      if (wc != c0 + 1 + i || wa !== DEPBIT'(i + 1) || wd !== 1'b0) begin
        n_err++;
        $display("FAIL clear_write[%0d]: cyc +%0d addr %0d data %b expected +%0d %0d 0",
                 i, wc - c0, wa, wd, i + 1, i + 1);
      end
    end
    // RAM started all ones: an empty frame must scan out no segments.
    feed_pixels('0);
    pulse_end(fe);
    wait_done(base, seen);
    n_vec++;
    if (!seen || obs_q.size() != 0 || bus.seg_cnt !== '0 || bus.seg_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL clear_empty_scan: done %b segs %0d cnt %0d ovf %b expected 1 0 0 0",
               seen, obs_q.size(), bus.seg_cnt, bus.seg_ovf);
    end
    last_cnt = 0;
    last_ovf = 1'b0;
  endtask

  task automatic test_frame(input string name, input logic [H_PIXEL-1:0] mask);
    int unsigned fe, base, ec, oc;
    int exp_cnt;
    bit exp_ovf, seen;
    logic [W-1:0] e, o;
    exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    build_exp(mask, exp_cnt, exp_ovf);
    base = done_cnt;
    run_frame(mask, fe);
    wait_done(base, seen);
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, 4 * H_PIXEL);
    end
    n_vec++;
    if (done_cyc != fe + H_PIXEL + 1) begin
      n_err++;
      $display("FAIL %s done_latency: got +%0d expected +%0d", name, done_cyc - fe, H_PIXEL + 1);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s seg_count: got %0d pulses expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e  = exp_q.pop_front();
      o  = obs_q.pop_front();
      oc = obs_cyc_q.pop_front();
      last_emit_cyc = oc;
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s seg: got [%0d,%0d] expected [%0d,%0d]",
                 name, o[W-1:DEPBIT], o[DEPBIT-1:0], e[W-1:DEPBIT], e[DEPBIT-1:0]);
      end
      ec = (int'(e[DEPBIT-1:0]) == H_PIXEL - 1) ? fe + H_PIXEL + 1 : fe + int'(e[DEPBIT-1:0]) + 3;
      n_vec++;
      if (oc != ec) begin
        n_err++;
        $display("FAIL %s seg_time [%0d,%0d]: got +%0d expected +%0d",
                 name, e[W-1:DEPBIT], e[DEPBIT-1:0], oc - fe, ec - fe);
      end
    end
    exp_q.delete();
    n_vec++;
    if (bus.seg_cnt !== SEG_BIT'(exp_cnt) || bus.seg_ovf !== exp_ovf) begin
      n_err++;
      $display("FAIL %s totals: cnt %0d ovf %b expected %0d %b", name, bus.seg_cnt, bus.seg_ovf, exp_cnt, exp_ovf);
    end
    n_vec++;
    if (done_cnt != base + 1 || dbg_state !== ST_IDLE || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: dones %0d state %0d busy %b expected 1 %0d 0",
               name, done_cnt - base, dbg_state, bus.busy, ST_IDLE);
    end
    last_cnt = exp_cnt;
    last_ovf = exp_ovf;
  endtask

  task automatic test_basic();
    logic [H_PIXEL-1:0] m;
    m = '0;
    m[2] = 1'b1; m[3] = 1'b1; m[4] = 1'b1; m[9] = 1'b1;
    test_frame("basic", m);
  endtask

  task automatic test_edge();
    logic [H_PIXEL-1:0] m;
    m = '0;
    m[H_PIXEL-2] = 1'b1; m[H_PIXEL-1] = 1'b1;
    test_frame("edge", m);
    n_vec++;
    if (last_emit_cyc != done_cyc) begin
      n_err++;
      $display("FAIL edge_with_done: seg_valid cycle %0d done cycle %0d expected equal", last_emit_cyc, done_cyc);
    end
    m = '0;
    m[0] = 1'b1; m[H_PIXEL-1] = 1'b1;
    for (int i = 16; i <= 20; i++) m[i] = 1'b1;
    test_frame("ends", m);
  endtask

  task automatic test_overflow();
    logic [H_PIXEL-1:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) begin
      m[3*i] = 1'b1;
      m[3*i+1] = 1'b1;
    end
    test_frame("overflow", m);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) test_frame("random", H_PIXEL'($urandom));
  endtask

  task automatic test_abort();
    int unsigned c0, fe, base;
    logic [H_PIXEL-1:0] m;
    pulse_start(c0);
    repeat (H_PIXEL) @(posedge clk);
    #1;
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_dat_q.delete();
    bus.pix_valid = 1'b1; bus.pix_bin = 1'b1; bus.pix_x = DEPBIT'(40);
    @(posedge clk); #1;
    bus.pix_x = DEPBIT'(H_PIXEL);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0; bus.pix_bin = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (wr_cyc_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_oob_write: got %0d writes expected 0", wr_cyc_q.size());
    end
    base = done_cnt;
    bus.pix_valid = 1'b1; bus.pix_bin = 1'b1; bus.pix_x = DEPBIT'(5);
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0; bus.pix_valid = 1'b0; bus.pix_bin = 1'b0;
    n_vec++;
    if (dbg_state !== ST_CLEAR || bus.ram_we !== 1'b1 || bus.ram_waddr !== DEPBIT'(1) || bus.ram_dq_i !== 1'b0) begin
      n_err++;
      $display("FAIL abort_accum_restart: state %0d we %b addr %0d dq %b expected %0d 1 1 0",
               dbg_state, bus.ram_we, bus.ram_waddr, bus.ram_dq_i, ST_CLEAR);
    end
    repeat (H_PIXEL) @(posedge clk);
    #1;
    m = '0;
    m[5] = 1'b1; m[6] = 1'b1; m[7] = 1'b1;
    feed_pixels(m);
    pulse_end(fe);
    repeat (8) @(posedge clk);
    #1;
    n_vec++;
    if (dbg_state !== ST_SCAN) begin
      n_err++;
      $display("FAIL abort_in_scan: state %0d expected %0d", dbg_state, ST_SCAN);
    end
    pulse_start(c0);
    repeat (3 * H_PIXEL) @(posedge clk);
    #1;
    n_vec++;
    if (done_cnt != base || bus.seg_cnt !== SEG_BIT'(last_cnt) || bus.seg_ovf !== last_ovf || dbg_state !== ST_ACCUM) begin
      n_err++;
      $display("FAIL abort_no_done: dones %0d cnt %0d ovf %b state %0d expected 0 %0d %b %0d",
               done_cnt - base, bus.seg_cnt, bus.seg_ovf, dbg_state, last_cnt, last_ovf, ST_ACCUM);
    end
  endtask

  task automatic test_reset_mid_scan();
    int unsigned fe, base;
    logic [3*DEPBIT+SEG_BIT+6:0] outs;
    base = done_cnt;
    pulse_end(fe);
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (dbg_state !== ST_SCAN) begin
      n_err++;
      $display("FAIL rst_scan_entry: state %0d expected %0d", dbg_state, ST_SCAN);
    end
    rst_n = 1'b0;
    #1;
    outs = {bus.ram_we, bus.ram_waddr, bus.ram_dq_i, bus.ram_raddr, bus.busy, bus.seg_valid,
            bus.seg_left, bus.seg_right, bus.seg_cnt, bus.seg_ovf, bus.done};
    n_vec++;
    if (outs !== '0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL rst_mid_scan: outputs %h state %0d expected 0 %0d", outs, dbg_state, ST_IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3 * H_PIXEL) @(posedge clk);
    #1;
    n_vec++;
    if (done_cnt != base || dbg_state !== ST_IDLE || bus.busy !== 1'b0 || bus.seg_cnt !== '0) begin
      n_err++;
      $display("FAIL rst_after: dones %0d state %0d busy %b cnt %0d expected 0 %0d 0 0",
               done_cnt - base, dbg_state, bus.busy, bus.seg_cnt, ST_IDLE);
    end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_bin     = 1'b0;
    bus.pix_x       = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_clear();
    test_basic();
    test_edge();
    test_overflow();
    test_random();
    test_abort();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
